// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the single-port program/data memory.
// Port 0 is the CPU memory port, port 1 is the loader/debug port.
module mem_arbiter #(
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_done,
    output logic [DW-1:0] ld_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

    state_t        state;
    logic          last_owner;
    logic          owner_q;
    logic          we_q;
    logic [1:0]    cnt;
    logic          any_req;
    logic          pick_ld;
    logic          grant;

    // On a tie the port that did not win last time gets the memory.
    always_comb begin
        any_req = cpu_req | ld_req;
        pick_ld = (cpu_req & ld_req) ? ~last_owner : ld_req;
        grant   = rst & (state == IDLE) & any_req;
    end

    assign cpu_gnt = grant & ~pick_ld;
    assign ld_gnt  = grant & pick_ld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            cnt        <= 2'd0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            cpu_done   <= 1'b0;
            ld_done    <= 1'b0;
            cpu_rdata  <= '0;
            ld_rdata   <= '0;
        end else begin
            cpu_done <= 1'b0;
            ld_done  <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_q    <= pick_ld;
                        last_owner <= pick_ld;
                        we_q       <= pick_ld ? ld_we : cpu_we;
                        mem_addr   <= pick_ld ? ld_addr : cpu_addr;
                        mem_wdata  <= pick_ld ? ld_wdata : cpu_wdata;
                        mem_en     <= 1'b1;
                        mem_we     <= pick_ld ? ld_we : cpu_we;
                        busy       <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        if (owner_q) ld_done  <= 1'b1;
                        else         cpu_done <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt   <= CNT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        // Memory data is valid in the last WAIT cycle.
                        if (owner_q) begin
                            ld_rdata <= mem_rdata;
                            ld_done  <= 1'b1;
                        end else begin
                            cpu_rdata <= mem_rdata;
                            cpu_done  <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model; a second instance runs with READ_LAT=4.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       cpu_req = 0, cpu_we = 0, ld_req = 0, ld_we = 0;
    logic [4:0] cpu_addr = 0, ld_addr = 0;
    logic [7:0] cpu_wdata = 0, ld_wdata = 0;
    logic       cpu_gnt, cpu_done, ld_gnt, ld_done;
    logic [7:0] cpu_rdata, ld_rdata;
    logic       mem_en, mem_we, busy;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic       d4_cpu_req = 0;
    logic [4:0] d4_cpu_addr = 0;
    logic       d4_cpu_gnt, d4_cpu_done, d4_ld_gnt, d4_ld_done;
    logic [7:0] d4_cpu_rdata, d4_ld_rdata;
    logic       d4_mem_en, d4_mem_we, d4_busy;
    logic [4:0] d4_mem_addr;
    logic [7:0] d4_mem_wdata, d4_mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] ref_mem [32];

    mem_arbiter #(.AW(5), .DW(8), .READ_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_done(ld_done), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.AW(5), .DW(8), .READ_LAT(4)) dut4 (
        .clk(clk), .rst(rst),
        .cpu_req(d4_cpu_req), .cpu_we(1'b0), .cpu_addr(d4_cpu_addr), .cpu_wdata(8'h00),
        .cpu_gnt(d4_cpu_gnt), .cpu_done(d4_cpu_done), .cpu_rdata(d4_cpu_rdata),
        .ld_req(1'b0), .ld_we(1'b0), .ld_addr(5'h00), .ld_wdata(8'h00),
        .ld_gnt(d4_ld_gnt), .ld_done(d4_ld_done), .ld_rdata(d4_ld_rdata),
        .mem_en(d4_mem_en), .mem_we(d4_mem_we), .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata),
        .mem_rdata(d4_mem_rdata), .busy(d4_busy)
    );

    function automatic logic [7:0] init_val(input logic [4:0] a);
        return (a == 5'h03) ? 8'hA5 : ({a[2:0], a} ^ 8'h96);
    endfunction

    // Memory models: registered read, data valid READ_LAT cycles after mem_en.
    logic [7:0] mem1 [32];
    bit         wr1  [32];
    logic [7:0] pipe1;
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem1[mem_addr] <= mem_wdata;
            wr1[mem_addr]  <= 1'b1;
        end
        pipe1 <= (mem_en && !mem_we) ?
                 (wr1[mem_addr] ? mem1[mem_addr] : init_val(mem_addr)) : 8'hEE;
    end
    assign mem_rdata = pipe1;

    logic [7:0] pipe4 [4];
    always @(posedge clk) begin
        pipe4[0] <= (d4_mem_en && !d4_mem_we) ? init_val(d4_mem_addr) : 8'hEE;
        for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
    end
    assign d4_mem_rdata = pipe4[3];

    task automatic do_reset();
        cpu_req = 0; ld_req = 0; d4_cpu_req = 0;
        rst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic test_reset();
        cpu_req = 1; ld_req = 1; d4_cpu_req = 1; rst = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({cpu_gnt, ld_gnt, cpu_done, ld_done, mem_en, mem_we, busy} !== 7'b0) begin
            n_bad++; $display("FAIL reset_ctrl got %b want 0", {cpu_gnt, ld_gnt, cpu_done, ld_done, mem_en, mem_we, busy}); end
        n_cmp++; if ({cpu_rdata, ld_rdata} !== 16'h0) begin
            n_bad++; $display("FAIL reset_rdata got %h want 0", {cpu_rdata, ld_rdata}); end
        n_cmp++; if ({mem_addr, mem_wdata} !== 13'h0) begin
            n_bad++; $display("FAIL reset_mem got %h want 0", {mem_addr, mem_wdata}); end
        n_cmp++; if ({d4_cpu_gnt, d4_ld_gnt, d4_cpu_done, d4_ld_done, d4_mem_en, d4_mem_we, d4_busy} !== 7'b0) begin
            n_bad++; $display("FAIL reset_d4_ctrl got nonzero"); end
        n_cmp++; if ({d4_cpu_rdata, d4_ld_rdata, d4_mem_addr, d4_mem_wdata} !== 29'h0) begin
            n_bad++; $display("FAIL reset_d4_data got %h want 0", {d4_cpu_rdata, d4_ld_rdata, d4_mem_addr, d4_mem_wdata}); end
        cpu_req = 0; ld_req = 0; d4_cpu_req = 0;
        @(posedge clk); #1 rst = 1;
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'h03; cpu_wdata = 8'h00;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (cpu_gnt !== (c == 0)) begin n_bad++; $display("FAIL rd_gnt c=%0d got %b", c, cpu_gnt); end
            n_cmp++; if (mem_en !== (c == 1)) begin n_bad++; $display("FAIL rd_mem_en c=%0d got %b", c, mem_en); end
            if (c == 1) begin
                n_cmp++; if ({mem_we, mem_addr} !== 6'h03) begin
                    n_bad++; $display("FAIL rd_mem_cmd got %h want 03", {mem_we, mem_addr}); end
            end
            n_cmp++; if (cpu_done !== (c == 3)) begin n_bad++; $display("FAIL rd_done c=%0d got %b", c, cpu_done); end
            n_cmp++; if (ld_done !== 1'b0) begin n_bad++; $display("FAIL rd_ld_done c=%0d got %b want 0", c, ld_done); end
            if (c >= 3) begin
                n_cmp++; if (cpu_rdata !== 8'hA5) begin n_bad++; $display("FAIL rd_data c=%0d got %h want a5", c, cpu_rdata); end
            end
            @(posedge clk); #1 cpu_req = 0;
        end
    endtask

    task automatic test_ld_write();
        ld_req = 1; ld_we = 1; ld_addr = 5'h1F; ld_wdata = 8'h3C;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++; if (ld_gnt !== (c == 0)) begin n_bad++; $display("FAIL wr_ld_gnt c=%0d got %b", c, ld_gnt); end
            n_cmp++; if (cpu_gnt !== (c == 3)) begin n_bad++; $display("FAIL wr_cpu_gnt c=%0d got %b", c, cpu_gnt); end
            n_cmp++; if (mem_en !== (c == 1 || c == 4)) begin n_bad++; $display("FAIL wr_mem_en c=%0d got %b", c, mem_en); end
            if (c == 1) begin
                n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 5'h1F, 8'h3C}) begin
                    n_bad++; $display("FAIL wr_mem_cmd got %h want 3f3c", {mem_we, mem_addr, mem_wdata}); end
            end
            n_cmp++; if (ld_done !== (c == 2)) begin n_bad++; $display("FAIL wr_ld_done c=%0d got %b", c, ld_done); end
            n_cmp++; if (cpu_done !== (c == 6)) begin n_bad++; $display("FAIL wr_cpu_done c=%0d got %b", c, cpu_done); end
            if (c == 6) begin
                n_cmp++; if (cpu_rdata !== 8'h3C) begin n_bad++; $display("FAIL wr_readback got %h want 3c", cpu_rdata); end
            end
            @(posedge clk); #1;
            if (c == 0) begin ld_req = 0; ld_we = 0; end
            if (c == 2) begin cpu_req = 1; cpu_we = 0; cpu_addr = 5'h1F; end
            if (c == 3) cpu_req = 0;
        end
        ref_mem[31] = 8'h3C;
    endtask

    task automatic test_lat4();
        d4_cpu_req = 1; d4_cpu_addr = 5'h03;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++; if (d4_cpu_gnt !== (c == 0)) begin n_bad++; $display("FAIL l4_gnt c=%0d got %b", c, d4_cpu_gnt); end
            n_cmp++; if (d4_mem_en !== (c == 1)) begin n_bad++; $display("FAIL l4_mem_en c=%0d got %b", c, d4_mem_en); end
            n_cmp++; if (d4_busy !== (c >= 1 && c <= 5)) begin n_bad++; $display("FAIL l4_busy c=%0d got %b", c, d4_busy); end
            n_cmp++; if (d4_cpu_done !== (c == 6)) begin n_bad++; $display("FAIL l4_done c=%0d got %b", c, d4_cpu_done); end
            if (c == 6) begin
                n_cmp++; if (d4_cpu_rdata !== 8'hA5) begin n_bad++; $display("FAIL l4_data got %h want a5", d4_cpu_rdata); end
            end
            @(posedge clk); #1 d4_cpu_req = 0;
        end
    endtask

    task automatic test_reset_mid();
        ld_req = 1; ld_we = 0; ld_addr = 5'h09;
        @(negedge clk);
        n_cmp++; if (ld_gnt !== 1'b1) begin n_bad++; $display("FAIL rm_gnt got %b want 1", ld_gnt); end
        @(posedge clk); #1 ld_req = 0;
        @(posedge clk); #1 rst = 0;
        #1;
        n_cmp++; if ({busy, mem_en, mem_we, ld_done, cpu_done, ld_gnt, cpu_gnt} !== 7'b0) begin
            n_bad++; $display("FAIL rm_ctrl got %b want 0", {busy, mem_en, mem_we, ld_done, cpu_done, ld_gnt, cpu_gnt}); end
        n_cmp++; if ({ld_rdata, cpu_rdata, mem_addr, mem_wdata} !== 29'h0) begin
            n_bad++; $display("FAIL rm_data got %h want 0", {ld_rdata, cpu_rdata, mem_addr, mem_wdata}); end
        @(posedge clk); #1 rst = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if ({ld_done, mem_en} !== 2'b00) begin n_bad++; $display("FAIL rm_after i=%0d got %b want 00", i, {ld_done, mem_en}); end
            @(posedge clk);
        end
        #1 cpu_req = 1; cpu_we = 0; cpu_addr = 5'h03;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (cpu_gnt !== (c == 0)) begin n_bad++; $display("FAIL rm_cpu_gnt c=%0d got %b", c, cpu_gnt); end
            n_cmp++; if (cpu_done !== (c == 3)) begin n_bad++; $display("FAIL rm_cpu_done c=%0d got %b", c, cpu_done); end
            if (c == 3) begin
                n_cmp++; if (cpu_rdata !== 8'hA5) begin n_bad++; $display("FAIL rm_cpu_data got %h want a5", cpu_rdata); end
            end
            @(posedge clk); #1 cpu_req = 0;
        end
    endtask

    task automatic test_back_to_back();
        cpu_req = 1; cpu_we = 1; cpu_addr = 5'd0; cpu_wdata = 8'h50;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++; if (cpu_gnt !== (c == 0 || c == 2 || c == 4)) begin n_bad++; $display("FAIL b2b_gnt c=%0d got %b", c, cpu_gnt); end
            n_cmp++; if (cpu_done !== (c == 2 || c == 4 || c == 6)) begin n_bad++; $display("FAIL b2b_done c=%0d got %b", c, cpu_done); end
            n_cmp++; if (mem_en !== (c == 1 || c == 3 || c == 5)) begin n_bad++; $display("FAIL b2b_mem_en c=%0d got %b", c, mem_en); end
            if (c == 1 || c == 3 || c == 5) begin
                n_cmp++; if ({mem_addr, mem_wdata} !== {5'(c / 2), 8'(8'h50 + c / 2)}) begin
                    n_bad++; $display("FAIL b2b_mem c=%0d got %h", c, {mem_addr, mem_wdata}); end
            end
            @(posedge clk); #1;
            if (c == 0) begin cpu_addr = 5'd1; cpu_wdata = 8'h51; end
            if (c == 2) begin cpu_addr = 5'd2; cpu_wdata = 8'h52; end
            if (c == 4) cpu_req = 0;
        end
        ref_mem[0] = 8'h50; ref_mem[1] = 8'h51; ref_mem[2] = 8'h52;
    endtask

    // Transaction-level model: one access at a time, round-robin on ties,
    // done at grant+2 for writes and grant+3 for reads (READ_LAT=1).
    task automatic run_model(input int ncyc, input bit contend);
        int free_at = 0, cd_at = -1, ldn_at = -1, en_at = -1, lat;
        bit last = 1'b1, gc, gl, w, cd_rd = 0, ld_rd = 0, en_we = 0;
        logic [4:0] a, en_addr = 0;
        logic [7:0] d, en_wd = 0, cd_data = 0, ld_data = 0, exp_crd = 0, exp_lrd = 0;
        do_reset();
        if (contend) begin
            cpu_req = 1; cpu_we = 0; cpu_addr = 5'h04;
            ld_req = 1; ld_we = 0; ld_addr = 5'h09;
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            gc = 0; gl = 0;
            if (c >= free_at && (cpu_req || ld_req)) begin
                gl = (cpu_req && ld_req) ? !last : ld_req;
                gc = !gl;
            end
            n_cmp++; if ({cpu_gnt, ld_gnt} !== {gc, gl}) begin
                n_bad++; $display("FAIL mdl_gnt c=%0d got %b want %b", c, {cpu_gnt, ld_gnt}, {gc, gl}); end
            n_cmp++; if ({cpu_done, ld_done} !== {c == cd_at, c == ldn_at}) begin
                n_bad++; $display("FAIL mdl_done c=%0d got %b want %b", c, {cpu_done, ld_done}, {c == cd_at, c == ldn_at}); end
            if (c == cd_at && cd_rd) exp_crd = cd_data;
            if (c == ldn_at && ld_rd) exp_lrd = ld_data;
            n_cmp++; if ({cpu_rdata, ld_rdata} !== {exp_crd, exp_lrd}) begin
                n_bad++; $display("FAIL mdl_rdata c=%0d got %h want %h", c, {cpu_rdata, ld_rdata}, {exp_crd, exp_lrd}); end
            n_cmp++; if ({mem_en, busy} !== {c == en_at, c < free_at}) begin
                n_bad++; $display("FAIL mdl_en_busy c=%0d got %b want %b", c, {mem_en, busy}, {c == en_at, c < free_at}); end
            if (c == en_at) begin
                n_cmp++; if ({mem_we, mem_addr} !== {en_we, en_addr}) begin
                    n_bad++; $display("FAIL mdl_cmd c=%0d got %h want %h", c, {mem_we, mem_addr}, {en_we, en_addr}); end
                if (en_we) begin
                    n_cmp++; if (mem_wdata !== en_wd) begin
                        n_bad++; $display("FAIL mdl_wdata c=%0d got %h want %h", c, mem_wdata, en_wd); end
                end
            end
            if (gc || gl) begin
                w = gl ? ld_we : cpu_we;
                a = gl ? ld_addr : cpu_addr;
                d = gl ? ld_wdata : cpu_wdata;
                lat = w ? 2 : 3;
                if (gl) begin ldn_at = c + lat; ld_rd = !w; ld_data = ref_mem[a]; end
                else    begin cd_at  = c + lat; cd_rd = !w; cd_data = ref_mem[a]; end
                if (w) ref_mem[a] = d;
                en_at = c + 1; en_we = w; en_addr = a; en_wd = d;
                free_at = c + lat; last = gl;
            end
            @(posedge clk); #1;
            if (!contend) begin
                if (gc || !cpu_req) begin
                    cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
                    cpu_addr = 5'($urandom_range(0, 31)); cpu_wdata = 8'($urandom);
                end
                if (gl || !ld_req) begin
                    ld_req = 1'($urandom_range(0, 1)); ld_we = 1'($urandom_range(0, 1));
                    ld_addr = 5'($urandom_range(0, 31)); ld_wdata = 8'($urandom);
                end
            end
        end
        cpu_req = 0; ld_req = 0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_contention();
        run_model(16, 1'b1);
    endtask

    task automatic test_random();
        run_model(600, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(5'(i));
        test_reset();
        test_cpu_read();
        test_ld_write();
        test_lat4();
        test_reset_mid();
        test_back_to_back();
        test_contention();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
